uart_tx_engine: RTL and testbench

UART transmit engine sitting directly downstream of the APB write/read control FSM. It captures one write byte per TXen assertion into a small FIFO and serializes each byte onto the `tx` line. The frame is start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It supplies the ready/empty status that the APB side uses to end its write-wait state.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_engine.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, default sizing and helpers for the UART transmit path.
//   tx_state_e        - serializer state encoding
//   UART_DATA_W       - default data bits per frame
//   UART_FIFO_DEPTH   - default transmit FIFO depth
//   UART_DIV_W        - default baud divisor width
//   uart_parity()     - parity bit for a data word (odd=1 selects odd parity)
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 4;
  localparam int UART_DIV_W      = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Caller zero-extends the data word; zero padding does not change the XOR.
  function automatic logic uart_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with wrap-around pointers.
//   i_clk / i_rst_n : clock, asynchronous active-low reset (flushes pointers)
//   i_wr / i_wdata  : write request and data; accepted when not full or when
//                     a read happens in the same cycle
//   i_rd            : read request; ignored while empty
//   o_rdata         : head-of-queue data (combinational from storage)
//   o_full          : count equals DEPTH
//   o_empty         : registered empty flag
//   o_count         : number of stored entries
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_empty;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_do_wr;
  logic             w_do_rd;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == (AW+1)'(DEPTH));
  assign w_do_rd      = i_rd & ~r_empty;
  assign w_do_wr      = i_wr & (~w_full | w_do_rd);
  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_do_wr};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_do_rd};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = r_empty;
  assign o_count = w_count;

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: captures one byte per TXen assertion into a FIFO and
// serializes it as start, DATA_W data bits LSB first, optional parity,
// then 1 or 2 stop bits.
//   PCLK, PRESETn  : clock, asynchronous active-low reset
//   TXen, wdata    : write enable (one byte per rising level) and data
//   run            : permits new frames to start
//   baud_div       : PCLK cycles per bit minus 1
//   parity_en/odd  : parity insertion and polarity
//   stop2          : two stop bits
//   clr_err        : clears overflow_err (a coincident drop wins)
//   tx             : registered serial line, idles high
//   tx_ready       : FIFO not full (combinational from count)
//   tx_busy        : serializer not idle (registered)
//   fifo_empty     : FIFO holds no bytes (registered)
//   overflow_err   : sticky, a byte was dropped
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int DIV_W      = UART_DIV_W
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TXen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              run,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              clr_err,
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              fifo_empty,
  output logic              overflow_err
);

  localparam int BCW = $clog2(DATA_W);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e          r_state, w_state_nxt;
  logic               r_txen_q;
  logic               r_ovf;
  logic [DATA_W-1:0]  r_shift,    w_shift_nxt;
  logic               r_par_bit,  w_par_bit_nxt;
  logic               r_par_en,   w_par_en_nxt;
  logic               r_stop2,    w_stop2_nxt;
  logic [DIV_W-1:0]   r_div,      w_div_nxt;
  logic [DIV_W-1:0]   r_baud_cnt, w_baud_nxt;
  logic [BCW-1:0]     r_bit_cnt,  w_bit_nxt;
  logic               r_stop_cnt, w_stop_nxt;
  logic               r_tx,       w_tx_nxt;
  logic               r_busy;

  logic               w_wr;
  logic               w_pop;
  logic               w_can_pop;
  logic               w_bit_end;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [DATA_W-1:0]  w_dout;
  logic [CW-1:0]      w_count;

  assign w_wr = TXen & ~r_txen_q;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_wr    (w_wr),
    .i_wdata (wdata),
    .i_rd    (w_pop),
    .o_rdata (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_drop    = w_wr & w_full & ~w_pop;
  assign w_can_pop = run & ~w_empty;
  assign w_bit_end = (r_baud_cnt == r_div);

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_par_bit_nxt = r_par_bit;
    w_par_en_nxt  = r_par_en;
    w_stop2_nxt   = r_stop2;
    w_div_nxt     = r_div;
    w_baud_nxt    = w_bit_end ? '0 : r_baud_cnt + DIV_W'(1);
    w_bit_nxt     = r_bit_cnt;
    w_stop_nxt    = r_stop_cnt;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;

    unique case (r_state)
      TX_IDLE: begin
        w_baud_nxt = '0;
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_state_nxt = TX_DATA;
          w_bit_nxt   = '0;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BCW'(DATA_W - 1)) begin
            w_state_nxt = r_par_en ? TX_PARITY : TX_STOP;
            w_stop_nxt  = 1'b0;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit_cnt + BCW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = TX_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_nxt = 1'b1;
          end else if (w_can_pop) begin
            // Chain straight into the next start bit: no idle cycle.
            w_pop       = 1'b1;
            w_state_nxt = TX_START;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase

    // Frame configuration is sampled only here, so mid-frame changes wait.
    if (w_pop) begin
      w_shift_nxt   = w_dout;
      w_par_bit_nxt = uart_parity(32'(w_dout), parity_odd);
      w_par_en_nxt  = parity_en;
      w_stop2_nxt   = stop2;
      w_div_nxt     = baud_div;
      w_baud_nxt    = '0;
    end

    // tx is registered from the next state so it changes with the state.
    unique case (w_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = w_shift_nxt[0];
      TX_PARITY: w_tx_nxt = w_par_bit_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= TX_IDLE;
      r_txen_q   <= 1'b0;
      r_ovf      <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_txen_q   <= TXen;
      r_ovf      <= w_drop ? 1'b1 : (clr_err ? 1'b0 : r_ovf);
      r_shift    <= w_shift_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_par_en   <= w_par_en_nxt;
      r_stop2    <= w_stop2_nxt;
      r_div      <= w_div_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != TX_IDLE);
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign fifo_empty   = w_empty;
  assign tx_ready     = (w_count < CW'(FIFO_DEPTH));
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic            TXen = 1'b0;
  logic [DW-1:0]   wdata = '0;
  logic            run = 1'b0;
  logic [DIVW-1:0] baud_div = '0;
  logic            parity_en = 1'b0;
  logic            parity_odd = 1'b0;
  logic            stop2 = 1'b0;
  logic            clr_err = 1'b0;
  logic            tx, tx_ready, tx_busy, fifo_empty, overflow_err;

  always #5 PCLK = ~PCLK;

  uart_tx_engine #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIVW)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .TXen         (TXen),
    .wdata        (wdata),
    .run          (run),
    .baud_div     (baud_div),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop2        (stop2),
    .clr_err      (clr_err),
    .tx           (tx),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .fifo_empty   (fifo_empty),
    .overflow_err (overflow_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the current frame as a bit list;
  // the line value is the bit at index (cycles since pop) / (bit period).
  logic [7:0] mq[$];
  bit         m_txen_q, m_active, m_ovf;
  int         m_cyc, m_len, m_div;
  bit         m_bits[12];

  always @(posedge PCLK or negedge PRESETn) begin : mdl
    bit         wr, pop, acc, p;
    logic [7:0] d;
    int         n;
    if (!PRESETn) begin
      mq.delete();
      m_txen_q = 0; m_active = 0; m_ovf = 0;
      m_cyc = 0; m_len = 0; m_div = 0;
    end else begin
      wr = TXen && !m_txen_q;
      m_txen_q = TXen;
      pop = 0;
      if (m_active) begin
        m_cyc++;
        if (m_cyc == m_len * (m_div + 1)) m_active = 0;
      end
      if (!m_active && run && mq.size() > 0) pop = 1;
      acc = wr && (mq.size() < DEPTH || pop);
      if (pop) begin
        d = mq.pop_front();
        m_div = int'(baud_div);
        n = 0;
        m_bits[n++] = 0;
        for (int i = 0; i < 8; i++) m_bits[n++] = d[i];
        if (parity_en) begin
          // total ones (data + parity) even for even parity, odd for odd
          p = (($countones(d) % 2) != int'(parity_odd));
          m_bits[n++] = p;
        end
        m_bits[n++] = 1;
        if (stop2) m_bits[n++] = 1;
        m_len = n;
        m_cyc = 0;
        m_active = 1;
      end
      if (acc) mq.push_back(wdata);
      if (wr && !acc) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
    end
  end

  bit chk_en = 0;

  always @(negedge PCLK) begin
    if (chk_en) begin
      check("m_tx", tx, m_active ? m_bits[m_cyc / (m_div + 1)] : 1'b1);
      check("m_busy", tx_busy, m_active);
      check("m_empty", fifo_empty, mq.size() == 0);
      check("m_ready", tx_ready, mq.size() < DEPTH);
      check("m_ovf", overflow_err, m_ovf);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #2;
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    wdata = d;
    TXen  = 1'b1;
    step(1);
    TXen  = 1'b0;
    step(1);
  endtask

  // Waits (bounded) for tx_busy, then records tx per cycle while busy.
  task automatic capture(output logic [31:0] bits, output int len);
    int w;
    bits = '0;
    len  = 0;
    w    = 0;
    @(negedge PCLK);
    while (!tx_busy && w < 50) begin
      @(negedge PCLK);
      w++;
    end
    check("cap_start", tx_busy, 1'b1);
    while (tx_busy && len < 4000) begin
      if (len < 32) bits[len] = tx;
      len++;
      @(negedge PCLK);
    end
    @(posedge PCLK);
    #2;
  endtask

  logic [9:0]  pat;
  logic [31:0] bits;
  int          len;
  int          w;
  int          r;

  initial begin
    run = 1'b1;
    baud_div = 16'd3;
    step(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_ovf", overflow_err, 1'b0);
    PRESETn = 1'b1;
    chk_en = 1;
    step(2);

    // Single byte 0xA5, 4 cycles per bit.
    pat = 10'b1101001010;
    wdata = 8'hA5;
    TXen = 1'b1;
    @(posedge PCLK);
    #2;
    TXen = 1'b0;
    @(negedge PCLK);
    check("sb_pre", tx, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      check("sb_bit", tx, pat[i / 4]);
      check("sb_busy", tx_busy, 1'b1);
    end
    @(negedge PCLK);
    check("sb_idle_tx", tx, 1'b1);
    check("sb_idle_busy", tx_busy, 1'b0);
    step(2);

    // Parity, one cycle per bit, two stop bits.
    baud_div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    pulse(8'h07);
    capture(bits, len);
    check("par_even_bit", bits[9], 1'b1);
    check("par_even_len", len, 12);
    check("par_start", bits[0], 1'b0);
    check("par_stop2", bits[11], 1'b1);
    parity_odd = 1'b1;
    pulse(8'h07);
    capture(bits, len);
    check("par_odd_bit", bits[9], 1'b0);
    check("par_odd_len", len, 12);
    step(2);

    // Back-to-back frames.
    baud_div = 16'd1; parity_en = 1'b0; stop2 = 1'b0;
    fork
      capture(bits, len);
      begin
        pulse(8'h11);
        pulse(8'h22);
        pulse(8'h33);
      end
    join
    check("b2b_len", len, 60);
    check("b2b_empty", fifo_empty, 1'b1);
    step(2);

    // Overflow with run low.
    run = 1'b0; baud_div = 16'd0;
    pulse(8'h31); pulse(8'h32); pulse(8'h33); pulse(8'h34);
    check("ovf_ready", tx_ready, 1'b0);
    check("ovf_pre", overflow_err, 1'b0);
    pulse(8'h35);
    check("ovf_set", overflow_err, 1'b1);
    step(10);
    check("ovf_sticky", overflow_err, 1'b1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("ovf_clr", overflow_err, 1'b0);
    run = 1'b1;
    capture(bits, len);
    check("ovf_len", len, 40);
    step(2);

    // TXen held high: one byte only.
    run = 1'b0;
    wdata = 8'h5A;
    TXen = 1'b1;
    step(20);
    TXen = 1'b0;
    step(1);
    check("held_nonempty", fifo_empty, 1'b0);
    check("held_ready", tx_ready, 1'b1);
    run = 1'b1;
    capture(bits, len);
    check("held_len", len, 10);
    check("held_empty", fifo_empty, 1'b1);
    step(2);

    // Reset during DATA with one byte still queued.
    baud_div = 16'd3;
    pulse(8'hC3);
    pulse(8'h3C);
    step(8);
    PRESETn = 1'b0;
    #1;
    check("rmf_tx", tx, 1'b1);
    check("rmf_busy", tx_busy, 1'b0);
    check("rmf_empty", fifo_empty, 1'b1);
    step(2);
    PRESETn = 1'b1;
    step(30);
    check("rmf_after_tx", tx, 1'b1);
    check("rmf_after_busy", tx_busy, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: begin
          wdata = 8'($urandom);
          TXen = 1'b1;
          step($urandom_range(1, 3));
          TXen = 1'b0;
          step($urandom_range(1, 4));
        end
        5: run = ($urandom_range(0, 3) != 0);
        6: begin
          baud_div   = 16'($urandom_range(0, 2));
          parity_en  = 1'($urandom);
          parity_odd = 1'($urandom);
          stop2      = 1'($urandom);
        end
        7: begin
          clr_err = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            wdata = 8'($urandom);
            TXen = 1'b1;
          end
          step(1);
          clr_err = 1'b0;
          TXen = 1'b0;
          step(1);
        end
        8: step($urandom_range(5, 40));
        default: repeat (6) pulse(8'($urandom));
      endcase
    end

    run = 1'b1;
    w = 0;
    while ((!fifo_empty || tx_busy) && w < 3000) begin
      step(1);
      w++;
    end
    check("drain_done", (fifo_empty && !tx_busy), 1'b1);
    step(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
